// File: rtl/alu_pkg.sv
// Shared ALU types: logic-unit operation select and skid-buffer state encoding.
package alu_pkg;

    typedef enum logic [1:0] {
        LOGIC_AND    = 2'b00,
        LOGIC_OR     = 2'b01,
        LOGIC_XOR    = 2'b10,
        LOGIC_PASS_A = 2'b11
    } logic_op_e;

    typedef enum logic [1:0] {
        SKID_EMPTY = 2'b00,
        SKID_ONE   = 2'b01,
        SKID_FULL  = 2'b10
    } skid_state_e;

endpackage

// File: rtl/logic_skid_buffer.sv
// Two-entry skid buffer (main + skid) with registered in_ready/out_valid; main drives the outputs.
module logic_skid_buffer
    import alu_pkg::*;
#(
    parameter int unsigned DW = 10
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data
);

    skid_state_e   state_q, state_d;
    logic [DW-1:0] main_q, main_d;
    logic [DW-1:0] skid_q, skid_d;
    logic          in_ready_q, in_ready_d;
    logic          out_valid_q, out_valid_d;
    logic          in_fire;
    logic          out_fire;

    assign in_fire  = in_valid & in_ready_q;
    assign out_fire = out_valid_q & out_ready;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        case (state_q)
            SKID_EMPTY: begin
                if (in_fire) begin
                    main_d  = in_data;
                    state_d = SKID_ONE;
                end
            end
            SKID_ONE: begin
                if (in_fire && !out_fire) begin
                    skid_d  = in_data;
                    state_d = SKID_FULL;
                end else if (!in_fire && out_fire) begin
                    state_d = SKID_EMPTY;
                end else if (in_fire && out_fire) begin
                    main_d  = in_data;
                end
            end
            SKID_FULL: begin
                if (out_fire) begin
                    main_d  = skid_q;
                    state_d = SKID_ONE;
                end
            end
            default: state_d = SKID_EMPTY;
        endcase
        // Handshake outputs are registered from the next state so out_ready never reaches in_ready combinationally.
        in_ready_d  = (state_d != SKID_FULL);
        out_valid_d = (state_d != SKID_EMPTY);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= SKID_EMPTY;
            main_q      <= '0;
            skid_q      <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            main_q      <= main_d;
            skid_q      <= skid_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = main_q;

endmodule

// File: rtl/logic_unit.sv
// Registered bitwise logic unit (AND/OR/XOR/PASS_A, optional invert) with zero/ones flags.
// Define LOGIC_UNIT_PARITY_EN to store and present an out_parity bit per result.
module logic_unit
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_op,
    input  logic             in_invert,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             out_zero,
    output logic             out_ones
`ifdef LOGIC_UNIT_PARITY_EN
    ,
    output logic             out_parity
`endif
);

`ifdef LOGIC_UNIT_PARITY_EN
    localparam int unsigned PW = WIDTH + 3;
`else
    localparam int unsigned PW = WIDTH + 2;
`endif

    logic_op_e        op;
    logic [WIDTH-1:0] raw;
    logic [WIDTH-1:0] res;
    logic             zero;
    logic             ones;
    logic [PW-1:0]    in_payload;
    logic [PW-1:0]    out_payload;

    always_comb begin
        op = logic_op_e'(in_op);
        case (op)
            LOGIC_AND:    raw = in_a & in_b;
            LOGIC_OR:     raw = in_a | in_b;
            LOGIC_XOR:    raw = in_a ^ in_b;
            LOGIC_PASS_A: raw = in_a;
            default:      raw = in_a;
        endcase
        res  = in_invert ? ~raw : raw;
        zero = (res == '0);
        ones = (res == '1);
`ifdef LOGIC_UNIT_PARITY_EN
        in_payload = {^res, ones, zero, res};
`else
        in_payload = {ones, zero, res};
`endif
    end

    logic_skid_buffer #(
        .DW(PW)
    ) u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_payload),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_payload)
    );

    assign out_result = out_payload[WIDTH-1:0];
    assign out_zero   = out_payload[WIDTH];
    assign out_ones   = out_payload[WIDTH+1];
`ifdef LOGIC_UNIT_PARITY_EN
    assign out_parity = out_payload[WIDTH+2];
`endif

endmodule

// File: tb/tb_logic_unit.sv
// Self-checking bench for logic_unit: directed steps plus a queue scoreboard fed on input fire.
module tb_logic_unit;
    localparam int unsigned W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [1:0]   in_op;
    logic         in_invert;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_result;
    logic         out_zero;
    logic         out_ones;
`ifdef LOGIC_UNIT_PARITY_EN
    logic         out_parity;
`endif

    int checks = 0;
    int errors = 0;
    logic [W+2:0] sb_q[$];

    always #5 clk = ~clk;

    logic_unit #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_invert  (in_invert),
        .in_a       (in_a),
        .in_b       (in_b),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_zero   (out_zero),
        .out_ones   (out_ones)
`ifdef LOGIC_UNIT_PARITY_EN
        ,
        .out_parity (out_parity)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Independent reference: {parity, ones, zero, result}
    function automatic logic [W+2:0] model(input logic [1:0] op, input logic inv,
                                            input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] r;
        case (op)
            2'b00:   r = a & b;
            2'b01:   r = a | b;
            2'b10:   r = a ^ b;
            default: r = a;
        endcase
        if (inv) r = ~r;
        return {^r, (r == {W{1'b1}}), (r == {W{1'b0}}), r};
    endfunction

    // Scoreboard: pop on output fire, push on input fire, flush on reset.
    always @(negedge clk) begin
        logic [W+2:0] e;
        if (!rst_n) begin
            sb_q.delete();
        end else begin
            if (out_valid && out_ready) begin
                if (sb_q.size() == 0) begin
                    check("sb_unexpected_beat", 32'd1, 32'd0);
                end else begin
                    e = sb_q.pop_front();
                    check("sb_result", 32'(out_result), 32'(e[W-1:0]));
                    check("sb_zero", 32'(out_zero), 32'(e[W]));
                    check("sb_ones", 32'(out_ones), 32'(e[W+1]));
`ifdef LOGIC_UNIT_PARITY_EN
                    check("sb_parity", 32'(out_parity), 32'(e[W+2]));
`endif
                end
            end
            if (in_valid && in_ready)
                sb_q.push_back(model(in_op, in_invert, in_a, in_b));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] op, input logic inv, input logic [W-1:0] a, input logic [W-1:0] b);
        in_valid  = 1'b1;
        in_op     = op;
        in_invert = inv;
        in_a      = a;
        in_b      = b;
    endtask

    // Offer one beat and return just after the edge that accepts it.
    task automatic send(input logic [1:0] op, input logic inv, input logic [W-1:0] a, input logic [W-1:0] b);
        bit done = 1'b0;
        drive(op, inv, a, b);
        for (int i = 0; i < 100 && !done; i++) begin
            @(negedge clk);
            if (in_ready) done = 1'b1;
            step();
        end
        if (!done) check("send_timeout", 32'd0, 32'd1);
        in_valid = 1'b0;
    endtask

    task automatic op_check(input string tag, input logic [1:0] op, input logic inv,
                            input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic [W-1:0] exp_r, input logic exp_z, input logic exp_o);
        send(op, inv, a, b);
        @(negedge clk);
        check({tag, "_valid"}, 32'(out_valid), 32'd1);
        check({tag, "_result"}, 32'(out_result), 32'(exp_r));
        check({tag, "_zero"}, 32'(out_zero), 32'(exp_z));
        check({tag, "_ones"}, 32'(out_ones), 32'(exp_o));
        step();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int accepted;
        logic [W-1:0] held;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_op     = '0;
        in_invert = 1'b0;
        in_a      = '0;
        in_b      = '0;

        // Reset with random inputs
        for (int i = 0; i < 3; i++) begin
            drive(2'($urandom), 1'($urandom), W'($urandom), W'($urandom));
            out_ready = 1'($urandom);
            @(negedge clk);
            check("rst_out_valid", 32'(out_valid), 32'd0);
            check("rst_in_ready", 32'(in_ready), 32'd1);
            check("rst_out_result", 32'(out_result), 32'd0);
            check("rst_flags", 32'({out_zero, out_ones}), 32'd0);
            step();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        rst_n     = 1'b1;
        step();

        // Operations
        op_check("and",       2'b00, 1'b0, 8'hF0, 8'h3C, 8'h30, 1'b0, 1'b0);
        op_check("and_inv",   2'b00, 1'b1, 8'hF0, 8'h3C, 8'hCF, 1'b0, 1'b0);
        op_check("or",        2'b01, 1'b0, 8'hF0, 8'h3C, 8'hFC, 1'b0, 1'b0);
        op_check("xor",       2'b10, 1'b0, 8'hF0, 8'h3C, 8'hCC, 1'b0, 1'b0);
        op_check("pass_inv",  2'b11, 1'b1, 8'hF0, 8'h3C, 8'h0F, 1'b0, 1'b0);
        op_check("xor_zero",  2'b10, 1'b0, 8'hAA, 8'hAA, 8'h00, 1'b1, 1'b0);
        op_check("xnor_ones", 2'b10, 1'b1, 8'hAA, 8'hAA, 8'hFF, 1'b0, 1'b1);
        op_check("or_zero",   2'b01, 1'b0, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0);

        // Backpressure: A, B accepted, C held until out_ready rises
        out_ready = 1'b0;
        step();
        drive(2'b11, 1'b0, 8'h11, 8'h00);
        @(negedge clk);
        check("bp_ready_a", 32'(in_ready), 32'd1);
        step();
        drive(2'b11, 1'b0, 8'h22, 8'h00);
        @(negedge clk);
        check("bp_ready_b", 32'(in_ready), 32'd1);
        step();
        drive(2'b11, 1'b0, 8'h33, 8'h00);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp_ready_c_held", 32'(in_ready), 32'd0);
            check("bp_stall_result", 32'(out_result), 32'h11);
            check("bp_stall_valid", 32'(out_valid), 32'd1);
            step();
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_out_a", 32'(out_result), 32'h11);
        step();
        @(negedge clk);
        check("bp_out_b", 32'(out_result), 32'h22);
        check("bp_ready_back", 32'(in_ready), 32'd1);
        step();
        in_valid = 1'b0;
        @(negedge clk);
        check("bp_out_c", 32'(out_result), 32'h33);
        step();
        @(negedge clk);
        check("bp_drained", 32'(out_valid), 32'd0);
        step();

        // Streaming 16 back-to-back beats
        for (int i = 0; i < 16; i++) begin
            drive(2'(i), 1'(i >> 2), W'(i * 17), W'(8'h5A ^ i));
            @(negedge clk);
            check("stream_ready", 32'(in_ready), 32'd1);
            if (i > 0) check("stream_valid", 32'(out_valid), 32'd1);
            step();
        end
        in_valid = 1'b0;
        @(negedge clk);
        check("stream_last_valid", 32'(out_valid), 32'd1);
        step();

`ifdef LOGIC_UNIT_PARITY_EN
        send(2'b11, 1'b0, 8'h07, 8'h00);
        @(negedge clk);
        check("parity_07", 32'(out_parity), 32'd1);
        step();
        send(2'b11, 1'b0, 8'h03, 8'h00);
        @(negedge clk);
        check("parity_03", 32'(out_parity), 32'd0);
        step();
        out_ready = 1'b0;
        send(2'b11, 1'b0, 8'h07, 8'h00);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("parity_stall", 32'(out_parity), 32'd1);
            step();
        end
        out_ready = 1'b1;
        step();
        step();
`endif

        // Reset while FULL
        out_ready = 1'b0;
        send(2'b01, 1'b0, 8'h81, 8'h02);
        send(2'b01, 1'b0, 8'h44, 8'h08);
        @(negedge clk);
        check("full_ready", 32'(in_ready), 32'd0);
        held = out_result;
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_valid", 32'(out_valid), 32'd0);
        check("midrst_ready", 32'(in_ready), 32'd1);
        check("midrst_result", 32'(out_result), 32'd0);
        step();
        step();
        rst_n = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("post_rst_no_stale", 32'(out_valid), 32'd0);
            step();
        end
        check("pre_rst_held", 32'(held), 32'h83);

        // Random traffic, 10k accepted beats
        accepted = 0;
        for (int cyc = 0; cyc < 60000 && accepted < 10000; cyc++) begin
            drive(2'($urandom), 1'($urandom), W'($urandom), W'($urandom));
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            if (in_valid && in_ready) accepted++;
            step();
        end
        check("rand_accepted", 32'(accepted), 32'd10000);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 10 && sb_q.size() != 0; i++) step();
        @(negedge clk);
        check("rand_sb_empty", 32'(sb_q.size()), 32'd0);
        check("rand_out_idle", 32'(out_valid), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
